// File: rtl/imm_encoder_stream_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : imm_encoder_stream_pkg
//  Description : Shared ImmSrc encodings and instruction-field keep masks.
//                The enum is shared with the immediate generator (imm_gen)
//                so that encoder and decoder agree on format selection.
//  Revision    : 1.0  initial release
// ============================================================================
package imm_encoder_stream_pkg;

    typedef enum logic [2:0] {
        IMM_I = 3'b000,
        IMM_S = 3'b001,
        IMM_U = 3'b010,
        IMM_B = 3'b101,
        IMM_J = 3'b110
    } imm_src_e;

    // Non-immediate template bits that survive for each format family.
    localparam logic [31:0] KEEP_I  = 32'h000F_FFFF;  // rs1/funct3/rd/opcode
    localparam logic [31:0] KEEP_SB = 32'h01FF_F07F;  // rs2/rs1/funct3/opcode
    localparam logic [31:0] KEEP_UJ = 32'h0000_0FFF;  // rd/opcode

endpackage : imm_encoder_stream_pkg
`default_nettype wire

// File: rtl/imm_encoder_stream_imm_pack.sv
`default_nettype none
// ============================================================================
//  Module      : imm_encoder_stream_imm_pack
//  Description : Combinational immediate packer. Scatters ImmExt into
//                instr[31:7] for the selected format, merges the kept
//                template fields and flags whether the value is encodable.
//  Ports       : src_i    ImmSrc format select
//                imm_i    ImmExt value to encode
//                instr_i  instruction template
//                instr_o  merged instruction word
//                legal_o  1 when imm_i fits the format and src_i is known
//  Revision    : 1.0  initial release
// ============================================================================
module imm_encoder_stream_imm_pack
    import imm_encoder_stream_pkg::*;
(
    input  logic [2:0]  src_i,
    input  logic [31:0] imm_i,
    input  logic [31:0] instr_i,
    output logic [31:0] instr_o,
    output logic        legal_o
);

    // Sign-extension checks: the upper bits must all replicate the top
    // encodable bit, otherwise the value is out of range.
    logic w_sext12;
    logic w_sext13;
    logic w_sext21;

    assign w_sext12 = (imm_i[31:11] == '0) || (imm_i[31:11] == '1);
    assign w_sext13 = (imm_i[31:12] == '0) || (imm_i[31:12] == '1);
    assign w_sext21 = (imm_i[31:20] == '0) || (imm_i[31:20] == '1);

    always_comb begin
        instr_o = 32'h0;
        legal_o = 1'b0;
        case (src_i)
            IMM_I: begin
                instr_o = {imm_i[11:0], 20'h0} | (instr_i & KEEP_I);
                legal_o = w_sext12;
            end
            IMM_S: begin
                instr_o = {imm_i[11:5], 13'h0, imm_i[4:0], 7'h0} | (instr_i & KEEP_SB);
                legal_o = w_sext12;
            end
            IMM_B: begin
                instr_o = {imm_i[12], imm_i[10:5], 13'h0, imm_i[4:1], imm_i[11], 7'h0}
                        | (instr_i & KEEP_SB);
                legal_o = w_sext13 && !imm_i[0];
            end
            IMM_U: begin
                instr_o = {imm_i[31:12], 12'h0} | (instr_i & KEEP_UJ);
                legal_o = (imm_i[11:0] == 12'h0);
            end
            IMM_J: begin
                instr_o = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], 12'h0}
                        | (instr_i & KEEP_UJ);
                legal_o = w_sext21 && !imm_i[0];
            end
            default: begin
                instr_o = 32'h0;
                legal_o = 1'b0;
            end
        endcase
    end

endmodule : imm_encoder_stream_imm_pack
`default_nettype wire

// File: rtl/imm_encoder_stream.sv
`default_nettype none
// ============================================================================
//  Module      : imm_encoder_stream
//  Description : Streams encoded instruction words to an instruction-memory
//                write port. Requests are packed by imm_pack; legal words get
//                a sequential address and pass through an output register
//                plus one skid register; illegal ones are dropped and logged
//                in a sticky error flag with the address they would have used.
//  Ports       : clk/rst              clock, synchronous active-high reset
//                in_valid/in_ready    request handshake (in_ready registered)
//                in_src/in_imm/in_instr  format, ImmExt, template
//                out_valid/out_ready  output handshake
//                out_addr/out_instr   word address and encoded word
//                err/err_addr/clr_err sticky drop flag, first drop address
//                count                emitted words, saturating
//  Revision    : 1.0  initial release
// ============================================================================
module imm_encoder_stream
    import imm_encoder_stream_pkg::*;
#(
    parameter int          ADDR_W    = 8,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_src,
    input  logic [31:0]       in_imm,
    input  logic [31:0]       in_instr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic [31:0]       out_instr,
    output logic              err,
    output logic [ADDR_W-1:0] err_addr,
    input  logic              clr_err,
    output logic [ADDR_W:0]   count
);

    localparam logic [ADDR_W-1:0] C_BASE = ADDR_W'(BASE_ADDR);

    logic [31:0]       w_pack_instr;
    logic              w_pack_legal;
    logic              w_accept;
    logic              w_push;
    logic              w_drop;
    logic              w_out_fire;

    logic              out_valid_q,  out_valid_d;
    logic [ADDR_W-1:0] out_addr_q,   out_addr_d;
    logic [31:0]       out_instr_q,  out_instr_d;
    logic              skid_valid_q, skid_valid_d;
    logic [ADDR_W-1:0] skid_addr_q,  skid_addr_d;
    logic [31:0]       skid_instr_q, skid_instr_d;
    logic [ADDR_W-1:0] next_addr_q,  next_addr_d;
    logic              err_q,        err_d;
    logic [ADDR_W-1:0] err_addr_q,   err_addr_d;
    logic [ADDR_W:0]   count_q,      count_d;

    imm_encoder_stream_imm_pack u_pack (
        .src_i   (in_src),
        .imm_i   (in_imm),
        .instr_i (in_instr),
        .instr_o (w_pack_instr),
        .legal_o (w_pack_legal)
    );

    // in_ready depends only on state, so it is glitch-free toward the source.
    assign w_accept   = in_valid && !skid_valid_q;
    assign w_push     = w_accept && w_pack_legal;
    assign w_drop     = w_accept && !w_pack_legal;
    assign w_out_fire = out_valid_q && out_ready;

    always_comb begin
        out_valid_d  = out_valid_q;
        out_addr_d   = out_addr_q;
        out_instr_d  = out_instr_q;
        skid_valid_d = skid_valid_q;
        skid_addr_d  = skid_addr_q;
        skid_instr_d = skid_instr_q;
        next_addr_d  = next_addr_q;
        err_d        = err_q;
        err_addr_d   = err_addr_q;
        count_d      = count_q;

        if (w_out_fire) begin
            out_valid_d = 1'b0;
            if (count_q != '1) begin
                count_d = count_q + (ADDR_W+1)'(1);
            end
        end

        // A full skid blocks acceptance, so refill from skid and a new push
        // are mutually exclusive.
        if (skid_valid_q) begin
            if (w_out_fire) begin
                out_valid_d  = 1'b1;
                out_addr_d   = skid_addr_q;
                out_instr_d  = skid_instr_q;
                skid_valid_d = 1'b0;
            end
        end else if (w_push) begin
            if (!out_valid_q || w_out_fire) begin
                out_valid_d = 1'b1;
                out_addr_d  = next_addr_q;
                out_instr_d = w_pack_instr;
            end else begin
                skid_valid_d = 1'b1;
                skid_addr_d  = next_addr_q;
                skid_instr_d = w_pack_instr;
            end
            next_addr_d = next_addr_q + ADDR_W'(1);
        end

        // A new drop wins over a simultaneous clear so the fresh error is kept.
        if (w_drop && (!err_q || clr_err)) begin
            err_d      = 1'b1;
            err_addr_d = next_addr_q;
        end else if (clr_err) begin
            err_d      = 1'b0;
            err_addr_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            out_addr_q   <= '0;
            out_instr_q  <= 32'h0;
            skid_valid_q <= 1'b0;
            skid_addr_q  <= '0;
            skid_instr_q <= 32'h0;
            next_addr_q  <= C_BASE;
            err_q        <= 1'b0;
            err_addr_q   <= '0;
            count_q      <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_addr_q   <= out_addr_d;
            out_instr_q  <= out_instr_d;
            skid_valid_q <= skid_valid_d;
            skid_addr_q  <= skid_addr_d;
            skid_instr_q <= skid_instr_d;
            next_addr_q  <= next_addr_d;
            err_q        <= err_d;
            err_addr_q   <= err_addr_d;
            count_q      <= count_d;
        end
    end

    assign in_ready  = !skid_valid_q;
    assign out_valid = out_valid_q;
    assign out_addr  = out_addr_q;
    assign out_instr = out_instr_q;
    assign err       = err_q;
    assign err_addr  = err_addr_q;
    assign count     = count_q;

endmodule : imm_encoder_stream
`default_nettype wire

// File: tb/tb_imm_encoder_stream.sv
`default_nettype none
// ============================================================================
//  Module      : tb_imm_encoder_stream
//  Description : Self-checking bench for imm_encoder_stream. A queue-based
//                reference model tracks held words, addresses, errors and
//                count; format packing and legality are recomputed from the
//                field placement rules and signed value ranges.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_imm_encoder_stream;
    import imm_encoder_stream_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    always #5 clk = ~clk;

    // Main instance: ADDR_W=8, BASE_ADDR=0
    logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1;
    logic [2:0]  in_src = 3'd0;
    logic [31:0] in_imm = 32'h0, in_instr = 32'h0, out_instr;
    logic [7:0]  out_addr, err_addr;
    logic        err, clr_err = 1'b0;
    logic [8:0]  count;

    // Small instance: ADDR_W=2, BASE_ADDR=3 (wrap and saturation)
    logic        b_in_valid = 1'b0, b_in_ready, b_out_valid;
    logic [2:0]  b_in_src = 3'd2;
    logic [31:0] b_in_imm = 32'h0, b_in_instr = 32'h37, b_out_instr;
    logic [1:0]  b_out_addr, b_err_addr;
    logic        b_err;
    logic [2:0]  b_count;

    imm_encoder_stream #(.ADDR_W(8), .BASE_ADDR(0)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_src(in_src), .in_imm(in_imm), .in_instr(in_instr),
        .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
        .out_instr(out_instr), .err(err), .err_addr(err_addr),
        .clr_err(clr_err), .count(count)
    );

    imm_encoder_stream #(.ADDR_W(2), .BASE_ADDR(3)) dut_b (
        .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_src(b_in_src), .in_imm(b_in_imm), .in_instr(b_in_instr),
        .out_valid(b_out_valid), .out_ready(1'b1), .out_addr(b_out_addr),
        .out_instr(b_out_instr), .err(b_err), .err_addr(b_err_addr),
        .clr_err(1'b0), .count(b_count)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic bit ref_legal(input logic [2:0] s, input logic [31:0] e);
        longint v;
        v = longint'($signed(e));
        case (s)
            3'b000, 3'b001: return (v >= -2048) && (v <= 2047);
            3'b101:         return (v >= -4096) && (v <= 4095) && (e % 2 == 0);
            3'b010:         return (e % 4096) == 0;
            3'b110:         return (v >= -(64'sd1 <<< 20)) && (v < (64'sd1 <<< 20)) && (e % 2 == 0);
            default:        return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] ref_enc(input logic [2:0] s, input logic [31:0] e,
                                            input logic [31:0] ins);
        logic [24:0] f;
        logic [31:0] keep;
        f = '0;
        keep = '0;
        case (s)
            3'b000: begin f[24:13] = e[11:0]; keep = 32'h000FFFFF; end
            3'b001: begin f[24:18] = e[11:5]; f[4:0] = e[4:0]; keep = 32'h01FFF07F; end
            3'b101: begin
                f[24] = e[12]; f[0] = e[11]; f[23:18] = e[10:5]; f[4:1] = e[4:1];
                keep = 32'h01FFF07F;
            end
            3'b010: begin f[24:5] = e[31:12]; keep = 32'h00000FFF; end
            3'b110: begin
                f[24] = e[20]; f[23:14] = e[10:1]; f[13] = e[11]; f[12:5] = e[19:12];
                keep = 32'h00000FFF;
            end
            default: ;
        endcase
        return (ins & keep) | {f, 7'b0};
    endfunction

    typedef struct {
        logic [7:0]  addr;
        logic [31:0] instr;
    } word_t;

    word_t      mq[$];
    logic [7:0] m_next = 8'd0;
    logic       m_err = 1'b0;
    logic [7:0] m_err_addr = 8'd0;
    int         m_count = 0;

    task automatic model_reset();
        mq.delete();
        m_next = 8'd0;
        m_err = 1'b0;
        m_err_addr = 8'd0;
        m_count = 0;
    endtask

    task automatic check_outputs();
        chk("in_ready", in_ready, mq.size() < 2);
        chk("out_valid", out_valid, mq.size() > 0);
        if (mq.size() > 0) begin
            chk("out_addr", out_addr, mq[0].addr);
            chk("out_instr", out_instr, mq[0].instr);
        end
        chk("err", err, m_err);
        chk("err_addr", err_addr, m_err_addr);
        chk("count", count, m_count);
    endtask

    // One clock cycle: called at a negedge, checks, drives, updates model, returns at next negedge.
    task automatic cyc(input logic v, input logic [2:0] s, input logic [31:0] e,
                       input logic [31:0] ins, input logic ordy, input logic clr);
        bit acc, fire, lg;
        word_t w;
        check_outputs();
        in_valid = v; in_src = s; in_imm = e; in_instr = ins;
        out_ready = ordy; clr_err = clr;
        acc  = v && (mq.size() < 2);
        fire = ordy && (mq.size() > 0);
        lg   = ref_legal(s, e);
        if (fire) begin
            void'(mq.pop_front());
            if (m_count < 511) m_count++;
        end
        if (acc && lg) begin
            w.addr = m_next;
            w.instr = ref_enc(s, e, ins);
            mq.push_back(w);
            m_next = m_next + 8'd1;
        end
        if (acc && !lg && (!m_err || clr)) begin
            m_err = 1'b1;
            m_err_addr = m_next;
        end else if (clr) begin
            m_err = 1'b0;
            m_err_addr = 8'd0;
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        clr_err = 1'b0;
    endtask

    typedef struct {
        logic [2:0]  src;
        logic [31:0] imm;
        logic [31:0] instr;
        logic [31:0] exp_instr;
        logic        exp_legal;
    } vec_t;

    vec_t vt[$];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r;
        logic [2:0]  srcs [8];
        logic [1:0]  exp_b;
        srcs = '{3'b000, 3'b001, 3'b101, 3'b010, 3'b110, 3'b011, 3'b100, 3'b111};

        // Known-answer table
        vt.push_back('{3'b000, 32'h000007FF, 32'hFFFFFFFF, 32'h7FFFFFFF, 1'b1});
        vt.push_back('{3'b000, 32'h00000800, 32'h00000013, 32'h0,        1'b0});
        vt.push_back('{3'b001, 32'hFFFFF800, 32'hFFFFFFFF, 32'h81FFF07F, 1'b1});
        vt.push_back('{3'b001, 32'h0000001F, 32'h00000023, 32'h00000FA3, 1'b1});
        vt.push_back('{3'b101, 32'hFFFFF000, 32'h00000063, 32'h80000063, 1'b1});
        vt.push_back('{3'b101, 32'h00000FFE, 32'h00000063, 32'h7E000FE3, 1'b1});
        vt.push_back('{3'b101, 32'h00001000, 32'h00000063, 32'h0,        1'b0});
        vt.push_back('{3'b010, 32'hFFFFF001, 32'h00000037, 32'h0,        1'b0});
        vt.push_back('{3'b010, 32'hABCDE000, 32'hFFFFFFFF, 32'hABCDEFFF, 1'b1});
        vt.push_back('{3'b110, 32'h000FFFFE, 32'h0000006F, 32'h7FFFF06F, 1'b1});
        vt.push_back('{3'b110, 32'hFFF00000, 32'hFFFFFFFF, 32'h80000FFF, 1'b1});
        vt.push_back('{3'b110, 32'h00100000, 32'h0000006F, 32'h0,        1'b0});
        vt.push_back('{3'b011, 32'h00000000, 32'h00000013, 32'h0,        1'b0});
        vt.push_back('{3'b111, 32'h00000000, 32'h00000013, 32'h0,        1'b0});

        // Reset
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_addr", out_addr, 8'd0);
        chk("rst_out_instr", out_instr, 32'h0);
        chk("rst_count", count, 9'd0);
        chk("rst_err", err, 1'b0);

        // I-type, latency N+1
        cyc(1'b1, 3'b000, 32'hFFFFF800, 32'h00000013, 1'b1, 1'b0);
        chk("i_valid", out_valid, 1'b1);
        chk("i_instr", out_instr, 32'h80000013);
        chk("i_addr", out_addr, 8'd0);
        // U then J
        cyc(1'b1, 3'b010, 32'h12345000, 32'h00000537, 1'b1, 1'b0);
        chk("u_instr", out_instr, 32'h12345537);
        chk("u_addr", out_addr, 8'd1);
        cyc(1'b1, 3'b110, 32'h00000800, 32'h0000006F, 1'b1, 1'b0);
        chk("j_instr", out_instr, 32'h0010006F);
        chk("j_addr", out_addr, 8'd2);
        // B legal, then misaligned drop, then reuse of the address
        cyc(1'b1, 3'b101, 32'h00000008, 32'h00000063, 1'b1, 1'b0);
        chk("b_instr", out_instr, 32'h00000463);
        chk("b_addr", out_addr, 8'd3);
        cyc(1'b1, 3'b101, 32'h00000009, 32'h00000063, 1'b1, 1'b0);
        chk("drop_err", err, 1'b1);
        chk("drop_err_addr", err_addr, 8'd4);
        chk("drop_no_out", out_valid, 1'b0);
        cyc(1'b1, 3'b101, 32'h00000008, 32'h00000063, 1'b1, 1'b0);
        chk("reuse_addr", out_addr, 8'd4);
        cyc(1'b0, 3'b000, 32'h0, 32'h0, 1'b1, 1'b1);
        chk("clr_err", err, 1'b0);

        // Backpressure: 3 back-to-back requests with sink stalled
        cyc(1'b1, 3'b000, 32'h1, 32'h13, 1'b0, 1'b0);
        cyc(1'b1, 3'b000, 32'h2, 32'h13, 1'b0, 1'b0);
        cyc(1'b1, 3'b000, 32'h3, 32'h13, 1'b0, 1'b0);
        chk("bp_in_ready", in_ready, 1'b0);
        chk("bp_hold_addr", out_addr, 8'd5);
        cyc(1'b1, 3'b000, 32'h3, 32'h13, 1'b1, 1'b0);
        cyc(1'b1, 3'b000, 32'h3, 32'h13, 1'b1, 1'b0);
        cyc(1'b0, 3'b000, 32'h0, 32'h0, 1'b1, 1'b0);
        chk("bp_third_addr", out_addr, 8'd7);
        chk("bp_third_instr", out_instr, 32'h00300013);
        cyc(1'b0, 3'b000, 32'h0, 32'h0, 1'b1, 1'b0);
        chk("bp_count", count, 9'd8);

        // Table-driven known answers
        foreach (vt[i]) begin
            cyc(1'b1, vt[i].src, vt[i].imm, vt[i].instr, 1'b1, 1'b0);
            if (vt[i].exp_legal) begin
                chk($sformatf("tbl%0d_valid", i), out_valid, 1'b1);
                chk($sformatf("tbl%0d_instr", i), out_instr, vt[i].exp_instr);
            end else begin
                chk($sformatf("tbl%0d_drop", i), {out_valid, err}, 2'b01);
            end
            cyc(1'b0, 3'b000, 32'h0, 32'h0, 1'b1, 1'b1);
        end

        // Randomized traffic against the model
        for (int k = 0; k < 400; k++) begin
            logic [2:0]  s;
            logic [31:0] e;
            r = $urandom;
            e = $urandom;
            case ($urandom_range(0, 4))
                1: e = {{20{e[11]}}, e[11:0]};
                2: e = {{19{e[12]}}, e[12:1], 1'b0};
                3: e = {e[31:12], 12'h0};
                4: e = {{11{e[20]}}, e[20:1], 1'b0};
                default: ;
            endcase
            s = srcs[$urandom_range(0, 7)];
            cyc(r[0] | r[1], s, e, $urandom, r[2] | r[3], (r[7:4] == 4'h0));
        end

        // Reset with output and skid both full
        cyc(1'b0, 3'b000, 32'h0, 32'h0, 1'b1, 1'b0);
        cyc(1'b0, 3'b000, 32'h0, 32'h0, 1'b1, 1'b0);
        cyc(1'b1, 3'b000, 32'h4, 32'h13, 1'b0, 1'b0);
        cyc(1'b1, 3'b000, 32'h5, 32'h13, 1'b0, 1'b0);
        chk("full_before_rst", in_ready, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        chk("rst2_out_valid", out_valid, 1'b0);
        chk("rst2_in_ready", in_ready, 1'b1);
        chk("rst2_count", count, 9'd0);
        chk("rst2_err", err, 1'b0);
        cyc(1'b1, 3'b000, 32'h6, 32'h13, 1'b1, 1'b0);
        chk("rst2_addr", out_addr, 8'd0);
        cyc(1'b0, 3'b000, 32'h0, 32'h0, 1'b1, 1'b0);

        // Small instance: address wrap from BASE_ADDR=3 and count saturation
        chk("b_count0", b_count, 3'd0);
        for (int k = 0; k < 9; k++) begin
            b_in_valid = 1'b1;
            b_in_imm = 32'(k) << 12;
            @(posedge clk);
            @(negedge clk);
            exp_b = 2'(3 + k);
            chk($sformatf("wrap%0d_valid", k), b_out_valid, 1'b1);
            chk($sformatf("wrap%0d_addr", k), b_out_addr, exp_b);
            chk($sformatf("wrap%0d_instr", k), b_out_instr, (32'(k) << 12) | 32'h37);
        end
        b_in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("b_count_sat", b_count, 3'd7);
        chk("b_err", b_err, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_imm_encoder_stream
`default_nettype wire
